// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU load/store port has priority, host/debug port gets a
// guaranteed slot via a saturating starvation counter and a req/ack handshake.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic        cpu_be_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic        host_be_i,
    input  logic [31:0] host_adr_i,
    input  logic [31:0] host_wdata_i,
    output logic [31:0] host_rdata_o,
    output logic        host_ack_o,
    output logic        mem_we_o,
    output logic        mem_be_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOST = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  starve_cnt_q;
    logic        host_ack_q;
    logic [31:0] host_rdata_q;

    logic starved;
    logic forced;
    logic grant;

    assign starved = (starve_cnt_q == LIMIT);
    assign grant   = (state_q == IDLE) && host_req_i && (!cpu_req_i || starved);
    // A forced grant steals the memory from an active CPU access this cycle.
    assign forced  = grant && cpu_req_i;

    always_comb begin
        mem_be_o    = cpu_be_i;
        mem_adr_o   = cpu_adr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_we_o    = cpu_req_i && cpu_we_i && !forced;
        cpu_stall_o = forced;
        if (state_q == HOST) begin
            mem_be_o    = host_be_i;
            mem_adr_o   = host_adr_i;
            mem_wdata_o = host_wdata_i;
            mem_we_o    = host_we_i;
            cpu_stall_o = cpu_req_i;
        end
        if (reset_i) begin
            mem_we_o    = 1'b0;
            cpu_stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    host_ack_q <= 1'b0;
                    if (grant) begin
                        state_q      <= HOST;
                        starve_cnt_q <= '0;
                    end else if (host_req_i && cpu_req_i && !starved) begin
                        starve_cnt_q <= starve_cnt_q + 8'd1;
                    end
                end
                HOST: begin
                    if (!host_we_i) host_rdata_q <= mem_rdata_i;
                    host_ack_q <= 1'b1;
                    state_q    <= ACK;
                end
                ACK: begin
                    host_ack_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    host_ack_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata_o  = mem_rdata_i;
    assign host_rdata_o = host_rdata_q;
    assign host_ack_o   = host_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cpu_req_i, cpu_we_i, cpu_be_i;
    logic [31:0] cpu_adr_i, cpu_wdata_i, cpu_rdata_o;
    logic        cpu_stall_o;
    logic        host_req_i, host_we_i, host_be_i;
    logic [31:0] host_adr_i, host_wdata_i, host_rdata_o;
    logic        host_ack_o;
    logic        mem_we_o, mem_be_o;
    logic [31:0] mem_adr_o, mem_wdata_o, mem_rdata_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] tmem [0:63];

    dmem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
        .cpu_adr_i(cpu_adr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_be_i(host_be_i),
        .host_adr_i(host_adr_i), .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o),
        .host_ack_o(host_ack_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = tmem[mem_adr_o[7:2]];
    always @(posedge clk_i) if (mem_we_o) tmem[mem_adr_o[7:2]] <= mem_wdata_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1-2 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_be_i = 1'b0;
        cpu_adr_i = 32'h80; cpu_wdata_i = 32'h0;
        host_req_i = 1'b0; host_we_i = 1'b0; host_be_i = 1'b0;
        host_adr_i = 32'h0; host_wdata_i = 32'h0;
        tick(); tick();
        #1;
        chk("rst_ack", {31'b0, host_ack_o}, 32'd0);
        chk("rst_rdata", host_rdata_o, 32'd0);
        chk("rst_stall", {31'b0, cpu_stall_o}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);

        reset_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("idle_mem_we", {31'b0, mem_we_o}, 32'd0);
            chk("idle_ack", {31'b0, host_ack_o}, 32'd0);
        end

        // Host write, CPU idle
        host_req_i = 1'b1; host_we_i = 1'b1; host_adr_i = 32'h40; host_wdata_i = 32'hDEADBEEF;
        #1;
        chk("hw_idle_stall", {31'b0, cpu_stall_o}, 32'd0);
        chk("hw_idle_we", {31'b0, mem_we_o}, 32'd0);
        tick(); #1;
        chk("hw_host_we", {31'b0, mem_we_o}, 32'd1);
        chk("hw_host_adr", mem_adr_o, 32'h40);
        chk("hw_host_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("hw_host_noack", {31'b0, host_ack_o}, 32'd0);
        tick(); #1;
        chk("hw_ack", {31'b0, host_ack_o}, 32'd1);
        chk("hw_mem", tmem[6'h10], 32'hDEADBEEF);
        host_req_i = 1'b0;
        tick(); #1;
        chk("hw_ack_drop", {31'b0, host_ack_o}, 32'd0);

        // Host read of the same word
        host_req_i = 1'b1; host_we_i = 1'b0;
        tick(); #1;
        chk("hr_host_we", {31'b0, mem_we_o}, 32'd0);
        chk("hr_host_adr", mem_adr_o, 32'h40);
        tick(); #1;
        chk("hr_ack", {31'b0, host_ack_o}, 32'd1);
        chk("hr_rdata", host_rdata_o, 32'hDEADBEEF);
        host_req_i = 1'b0;
        tick();

        // CPU priority: 8 denied cycles, then forced grant
        host_req_i = 1'b1; host_we_i = 1'b1; host_adr_i = 32'h44; host_wdata_i = 32'hCAFEF00D;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 32'h80;
        for (int i = 0; i < 8; i++) begin
            cpu_wdata_i = 32'h100 + 32'(i);
            #1;
            chk("prio_stall", {31'b0, cpu_stall_o}, 32'd0);
            chk("prio_cpu_we", {31'b0, mem_we_o}, 32'd1);
            tick();
        end
        chk("prio_cpu_mem", tmem[6'h20], 32'h107);
        cpu_adr_i = 32'h84; cpu_wdata_i = 32'h22222222;
        #1;
        chk("forced_stall", {31'b0, cpu_stall_o}, 32'd1);
        chk("forced_we", {31'b0, mem_we_o}, 32'd0);
        tick(); #1;
        chk("fhost_stall", {31'b0, cpu_stall_o}, 32'd1);
        chk("fhost_adr", mem_adr_o, 32'h44);
        chk("fhost_we", {31'b0, mem_we_o}, 32'd1);
        tick(); #1;
        host_req_i = 1'b0;
        chk("fack_ack", {31'b0, host_ack_o}, 32'd1);
        chk("fack_rdata_kept", host_rdata_o, 32'hDEADBEEF);
        chk("fack_stall", {31'b0, cpu_stall_o}, 32'd0);
        chk("fack_cpu_adr", mem_adr_o, 32'h84);
        chk("fack_cpu_we", {31'b0, mem_we_o}, 32'd1);
        chk("fhost_mem", tmem[6'h11], 32'hCAFEF00D);
        tick(); #1;
        chk("cpu_store_late", tmem[6'h21], 32'h22222222);
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        tick();

        // Idle-window grant: counter reaches 3, then a CPU gap grants unforced
        host_req_i = 1'b1; host_we_i = 1'b0; host_adr_i = 32'h44;
        cpu_req_i = 1'b1; cpu_adr_i = 32'h80;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("win_wait_stall", {31'b0, cpu_stall_o}, 32'd0);
            tick();
        end
        cpu_req_i = 1'b0;
        #1;
        chk("win_gap_stall", {31'b0, cpu_stall_o}, 32'd0);
        tick();
        cpu_req_i = 1'b1;
        #1;
        chk("win_host_stall", {31'b0, cpu_stall_o}, 32'd1);
        chk("win_host_adr", mem_adr_o, 32'h44);
        tick(); #1;
        host_req_i = 1'b0;
        chk("win_ack", {31'b0, host_ack_o}, 32'd1);
        chk("win_rdata", host_rdata_o, 32'hCAFEF00D);
        chk("win_ack_stall", {31'b0, cpu_stall_o}, 32'd0);
        tick();

        // Counter must have cleared: another full 8 denied cycles
        host_req_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("clr_wait_stall", {31'b0, cpu_stall_o}, 32'd0);
            tick();
        end
        #1;
        chk("clr_forced_stall", {31'b0, cpu_stall_o}, 32'd1);
        tick(); tick(); #1;
        host_req_i = 1'b0;
        chk("clr_ack", {31'b0, host_ack_o}, 32'd1);
        cpu_req_i = 1'b0;
        tick();

        // Byte write, then reset during ACK
        host_req_i = 1'b1; host_we_i = 1'b1; host_be_i = 1'b1;
        host_adr_i = 32'h4C; host_wdata_i = 32'h000000AB;
        tick(); #1;
        chk("byte_mem_be", {31'b0, mem_be_o}, 32'd1);
        chk("byte_mem_we", {31'b0, mem_we_o}, 32'd1);
        tick(); #1;
        chk("byte_ack", {31'b0, host_ack_o}, 32'd1);
        reset_i = 1'b1; host_req_i = 1'b0; host_be_i = 1'b0;
        tick(); #1;
        chk("abort_ack", {31'b0, host_ack_o}, 32'd0);
        chk("abort_rdata", host_rdata_o, 32'd0);
        reset_i = 1'b0;
        host_req_i = 1'b1; host_we_i = 1'b0; cpu_adr_i = 32'h80;
        tick(); #1;
        chk("post_rst_host_adr", mem_adr_o, 32'h4C);
        chk("post_rst_host_we", {31'b0, mem_we_o}, 32'd0);
        tick(); #1;
        host_req_i = 1'b0;
        chk("post_rst_ack", {31'b0, host_ack_o}, 32'd1);
        chk("post_rst_rdata", host_rdata_o, 32'h000000AB);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory between the MIPS core's load/store port and a host/debug port used for program loading and memory inspection. The block sits between the core and `dmem` in the top level and multiplexes address, write data, write enable and byte enable onto the memory. The CPU has priority. A starvation counter guarantees the host a slot, stalling the CPU for one cycle when needed. Host transfers use a req/ack handshake with registered read data.

## Interface
Parameters:
- STARVE_LIMIT, 8: number of consecutive denied host cycles before the host is forced onto the memory (range 1–255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU performs a load or store this cycle.
- cpu_we  in  1  CPU store (memwrite).
- cpu_be  in  1  CPU byte_enable (byte access).
- cpu_adr  in  32  CPU data address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  read data to the CPU.
- cpu_stall  out  1  CPU must hold its current instruction this cycle.
- host_req  in  1  host transfer request; held high with stable fields until host_ack.
- host_we  in  1  host write.
- host_be  in  1  host byte access.
- host_adr  in  32  host address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  registered host read data.
- host_ack  out  1  one-cycle completion pulse.
- mem_we  out  1  to dmem write enable.
- mem_be  out  1  to dmem byte_enable.
- mem_adr  out  32  to dmem address.
- mem_wdata  out  32  to dmem write data.
- mem_rdata  in  32  from dmem; combinational read.

## Operation
- FSM states: IDLE, HOST, ACK.
- IDLE:
  - Go to HOST when host_req=1 and either cpu_req=0 or starve_cnt==STARVE_LIMIT.
  - In the forced case, cpu_stall=1 combinationally in that same IDLE cycle. mem_we=0 that cycle, and the CPU access does not reach memory.
- starve_cnt (8-bit):
  - Increments in each IDLE cycle with host_req=1 and cpu_req=1 that does not transition to HOST.
  - Saturates at STARVE_LIMIT.
  - Clears on the IDLE→HOST transition and on reset.
- HOST (exactly one cycle):
  - The memory mux selects the host fields, with mem_we=host_we.
  - cpu_stall=1 if cpu_req=1.
  - On reads, mem_rdata is captured into host_rdata at the edge. On writes, host_rdata keeps its previous value.
  - Next state is ACK.
- ACK (one cycle):
  - host_ack=1 as a registered output. The host must drop or change host_req after this cycle.
  - The CPU owns the memory, and no host grant is possible. This gives a guaranteed one-cycle CPU window between host transfers.
  - Next state is IDLE.
- CPU path, when not stalled and not in HOST:
  - mem_* = cpu_*, with mem_we = cpu_req & cpu_we.
- cpu_rdata = mem_rdata at all times. It is only meaningful when the CPU owns the memory.
- With no requester, mem_we=0 and the address/data fields follow the CPU inputs.

## Timing
- Reset values (outputs and state):
  - state=IDLE, starve_cnt=0, host_ack=0, host_rdata=0, cpu_stall=0, mem_we=0.
  - mem_we and cpu_stall are held 0 while reset=1.
- Host latency: a request accepted in IDLE at cycle N gives memory access at N+1, then host_ack and host_rdata valid at N+2. Minimum host transfer is 3 cycles from request to ack, with an idle CPU.
- Worst-case host latency with continuous CPU traffic is STARVE_LIMIT+3 cycles from host_req rising to host_ack.
- CPU stall is at most 2 consecutive cycles per host transfer (forced IDLE cycle plus HOST). It is 1 cycle when the grant is not forced and the CPU requests during HOST.
- Simultaneous requests in IDLE: the CPU wins unless starve_cnt==STARVE_LIMIT.
- Reset mid-transfer (in HOST or ACK): any write already clocked in HOST stands. No host_ack is issued, and the host must re-issue.
- host_req dropped before ack: protocol violation. The FSM completes the sequence regardless.

## Test plan
- Reset check: assert reset 2 cycles → all outputs at their reset values. Release, idle 3 cycles → mem_we=0 and no ack.
- Host write then read, CPU idle:
  - Host write 0xDEADBEEF to 0x40 → host_ack 2 cycles after the request is taken.
  - Host read of 0x40 → host_rdata=0xDEADBEEF with host_ack.
- CPU priority: CPU stores continuously while host_req is held.
  - With STARVE_LIMIT=8, the host is granted after exactly 8 denied cycles, with cpu_stall=1 on the forced cycle and the HOST cycle.
  - The CPU store data lands only after the stall releases.
- Idle-window grant: CPU issues cpu_req=0 for one cycle while the host waits → grant with no forced stall. starve_cnt clears.
- Byte access and reset abort:
  - Host byte write (host_be=1) is passed to mem_be in HOST.
  - Reset asserted during ACK → host_ack is deasserted at the next edge, and state=IDLE.
